// File: rtl/uart_tx_drain_if.sv
// FIFO read-side handshake between the byte FIFO and the serial drain.
// master: the drain, which consumes the head byte and issues pops; slave: the FIFO.
interface uart_tx_drain_if;
    logic [7:0] i_fifo_data;
    logic       i_fifo_empty;
    logic       o_fifo_rd_en;

    modport master (
        input  i_fifo_data,
        input  i_fifo_empty,
        output o_fifo_rd_en
    );

    modport slave (
        output i_fifo_data,
        output i_fifo_empty,
        input  o_fifo_rd_en
    );
endinterface

// File: rtl/uart_tx_drain.sv
// 8N1 serial transmitter that pops one byte per frame from a first-word-fall-through FIFO.
// The bit period (i_div + 1 cycles) is captured at frame start and held for the whole frame.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line high, waiting for i_en with a non-empty FIFO; pops here only
// START | start bit, line low for D+1 cycles
// DATA  | 8 data bits LSB first, D+1 cycles each, idx_q selects the bit
// STOP  | stop bit, line high for D+1 cycles, o_done in its last cycle
module uart_tx_drain #(
    parameter int DIV_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic [DIV_W-1:0]   i_div,
    uart_tx_drain_if.master    fifo,
    output logic               o_txd,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_n;
    logic [DIV_W-1:0] cnt_q, cnt_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [7:0]       shift_q, shift_n;
    logic [2:0]       idx_q, idx_n;
    logic             txd_q, txd_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             launch;
    logic             bit_end;

    assign launch  = (state_q == IDLE) && i_en && !fifo.i_fifo_empty;
    assign bit_end = (cnt_q == '0);

    // The FSM uses the ungated launch; only the pop strobe is held off during reset.
    assign fifo.o_fifo_rd_en = launch && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            div_q   <= div_n;
            shift_q <= shift_n;
            idx_q   <= idx_n;
            txd_q   <= txd_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        div_n   = div_q;
        shift_n = shift_q;
        idx_n   = idx_q;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_n = START;
                    shift_n = fifo.i_fifo_data;
                    div_n   = i_div;
                    cnt_n   = i_div;
                    idx_n   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    cnt_n   = div_q;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n   = div_q;
                    shift_n = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx_q + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the flops present them in the
    // same cycle the FSM occupies that state.
    always_comb begin
        busy_n = (state_n != IDLE);
        done_n = (state_n == STOP) && (cnt_n == '0);
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            default: txd_n = 1'b1;
        endcase
    end

    assign o_txd  = txd_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: an emulated FIFO feeds the drain while a frame-level model
// predicts line, busy, done and pop every cycle from bit-index arithmetic.
module tb_uart_tx_drain;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_en;
    logic [DIV_W-1:0] i_div;
    logic             o_txd;
    logic             o_busy;
    logic             o_done;

    uart_tx_drain_if fifo_if ();

    uart_tx_drain #(.DIV_W(DIV_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (i_en),
        .i_div  (i_div),
        .fifo   (fifo_if),
        .o_txd  (o_txd),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] fifo_q[$];
    int         pop_cycles[$];
    logic [7:0] popped[$];
    int         busy_lens[$];
    int         busy_run = 0;
    int         done_cnt = 0;

    // frame-level reference: a frame is 10 bits of (m_d+1) cycles, m_t counts cycles into it
    bit         m_active = 1'b0;
    int         m_t = 0;
    int         m_d = 0;
    logic [7:0] m_byte = 8'h00;

    task automatic chk_bit(string name, logic obs, logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic chk_int(string name, int obs, int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic drive_fifo();
        fifo_if.i_fifo_empty = (fifo_q.size() == 0);
        fifo_if.i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic check_outputs(string tag, output logic e_pop);
        logic e_txd, e_busy, e_done;
        int   bitn;
        e_pop  = rst_n && !m_active && i_en && (fifo_q.size() != 0);
        e_txd  = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (m_active) begin
            bitn   = m_t / (m_d + 1);
            e_busy = 1'b1;
            if (bitn == 0)      e_txd = 1'b0;
            else if (bitn <= 8) e_txd = m_byte[bitn-1];
            e_done = (m_t == 10 * (m_d + 1) - 1);
        end
        chk_bit({tag, ".txd"},   o_txd,                e_txd);
        chk_bit({tag, ".busy"},  o_busy,               e_busy);
        chk_bit({tag, ".done"},  o_done,               e_done);
        chk_bit({tag, ".rd_en"}, fifo_if.o_fifo_rd_en, e_pop);
    endtask

    task automatic tick(string tag);
        logic             e_pop, rd_seen, busy_seen, done_seen;
        logic [7:0]       head;
        logic [DIV_W-1:0] div_s;
        @(negedge clk);
        check_outputs(tag, e_pop);
        rd_seen   = fifo_if.o_fifo_rd_en;
        busy_seen = o_busy;
        done_seen = o_done;
        head      = fifo_if.i_fifo_data;
        div_s     = i_div;
        @(posedge clk);
        cyc++;
        if (busy_seen === 1'b1) begin
            busy_run++;
        end else if (busy_run > 0) begin
            busy_lens.push_back(busy_run);
            busy_run = 0;
        end
        if (done_seen === 1'b1) done_cnt++;
        if (!rst_n) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_t++;
            if (m_t == 10 * (m_d + 1)) m_active = 1'b0;
        end else if (e_pop) begin
            m_active = 1'b1;
            m_t      = 0;
            m_d      = int'(div_s);
            m_byte   = head;
        end
        if (rd_seen === 1'b1 && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            pop_cycles.push_back(cyc);
            popped.push_back(head);
        end
        #1;
        drive_fifo();
    endtask

    task automatic run_to_idle(string tag, int max_cycles);
        int n = 0;
        while ((m_active || (rst_n && i_en && fifo_q.size() != 0)) && n < max_cycles) begin
            tick(tag);
            n++;
        end
        chk_int({tag, ".bounded"}, (n < max_cycles) ? 1 : 0, 1);
    endtask

    task automatic clear_logs();
        pop_cycles.delete();
        popped.delete();
        busy_lens.delete();
        busy_run = 0;
        done_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark;
        int n;

        // reset held with a non-empty FIFO and enable high
        rst_n = 1'b0;
        i_en  = 1'b1;
        i_div = 16'd3;
        fifo_q.push_back(8'hA5);
        drive_fifo();
        repeat (3) tick("reset");

        // single byte 0xA5, D=3, pops on the first cycle after release
        rst_n = 1'b1;
        clear_logs();
        mark = cyc;
        run_to_idle("single", 200);
        repeat (2) tick("single.tail");
        chk_int("single.pops", pop_cycles.size(), 1);
        chk_int("single.pop_at", pop_cycles[0], mark + 1);
        chk_int("single.busy_len", busy_lens[0], 40);
        chk_int("single.done_cnt", done_cnt, 1);

        // back-to-back with D=0
        clear_logs();
        i_div = 16'd0;
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h3C);
        drive_fifo();
        run_to_idle("b2b", 200);
        repeat (2) tick("b2b.tail");
        chk_int("b2b.pops", pop_cycles.size(), 3);
        chk_int("b2b.gap01", pop_cycles[1] - pop_cycles[0], 11);
        chk_int("b2b.gap12", pop_cycles[2] - pop_cycles[1], 11);
        chk_int("b2b.frames", busy_lens.size(), 3);
        chk_int("b2b.busy_len", busy_lens[2], 10);

        // enable dropped mid-frame with a second byte queued
        clear_logs();
        i_div = 16'd2;
        fifo_q.push_back(8'h55);
        fifo_q.push_back(8'h99);
        drive_fifo();
        n = 0;
        while (!(m_active && m_t >= 5) && n < 50) begin
            tick("gate.pre");
            n++;
        end
        i_en = 1'b0;
        run_to_idle("gate.finish", 100);
        repeat (15) tick("gate.hold");
        chk_int("gate.pops", pop_cycles.size(), 1);
        chk_int("gate.queued", fifo_q.size(), 1);
        chk_int("gate.busy_len", busy_lens[0], 30);
        mark = cyc;
        i_en = 1'b1;
        tick("gate.resume");
        chk_int("gate.resume_pop", pop_cycles[1], mark + 1);
        run_to_idle("gate.second", 100);
        repeat (2) tick("gate.tail");

        // divisor changed during DATA only affects the next frame
        clear_logs();
        i_div = 16'd7;
        fifo_q.push_back(8'h3A);
        fifo_q.push_back(8'hC1);
        drive_fifo();
        n = 0;
        while (!(m_active && m_t >= 20) && n < 100) begin
            tick("div.pre");
            n++;
        end
        i_div = 16'd1;
        run_to_idle("div", 400);
        repeat (2) tick("div.tail");
        chk_int("div.pops", pop_cycles.size(), 2);
        chk_int("div.first_len", busy_lens[0], 80);
        chk_int("div.second_len", busy_lens[1], 20);

        // reset during data bit 4 of 0x6B (bit value 0)
        clear_logs();
        i_div = 16'd1;
        fifo_q.push_back(8'h6B);
        fifo_q.push_back(8'h2D);
        drive_fifo();
        n = 0;
        while (!(m_active && (m_t / (m_d + 1)) == 5) && n < 100) begin
            tick("rst.pre");
            n++;
        end
        rst_n    = 1'b0;
        m_active = 1'b0;
        busy_run = 0;
        #1;
        chk_bit("rst.async_txd", o_txd, 1'b1);
        chk_bit("rst.async_busy", o_busy, 1'b0);
        chk_bit("rst.async_rd_en", fifo_if.o_fifo_rd_en, 1'b0);
        repeat (2) tick("rst.hold");
        rst_n = 1'b1;
        mark  = cyc;
        run_to_idle("rst.after", 100);
        repeat (2) tick("rst.tail");
        chk_int("rst.pops", pop_cycles.size(), 2);
        chk_int("rst.second_byte", int'(popped[1]), 8'h2D);
        chk_int("rst.repop_at", pop_cycles[1], mark + 1);
        chk_int("rst.drained", fifo_q.size(), 0);

        // largest divisor: bits last 65536 cycles, so the start bit is still on after 300
        clear_logs();
        i_div = 16'hFFFF;
        fifo_q.push_back(8'h81);
        drive_fifo();
        repeat (300) tick("maxdiv");
        chk_bit("maxdiv.busy", o_busy, 1'b1);
        rst_n    = 1'b0;
        m_active = 1'b0;
        busy_run = 0;
        tick("maxdiv.rst");
        rst_n = 1'b1;
        repeat (2) tick("maxdiv.idle");

        // randomized traffic, divisor and enable
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) != 0) fifo_q.push_back(8'($urandom));
            i_div = 16'($urandom_range(0, 4));
            i_en  = ($urandom_range(0, 3) != 0);
            drive_fifo();
            repeat ($urandom_range(1, 25)) tick("rand");
        end
        i_en = 1'b1;
        run_to_idle("rand.drain", 3000);
        repeat (2) tick("rand.tail");
        chk_int("rand.drained", fifo_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
